// File: rtl/router_pkg.sv
// router_pkg: shared packet geometry and requester indices for router port logic
package router_pkg;
  localparam int PKT_W = 16;
  localparam int DX_HI = 15;
  localparam int DX_LO = 12;
  localparam int DY_HI = 11;
  localparam int DY_LO = 8;
  localparam int PL_HI = 7;
  localparam int PL_LO = 0;
  localparam int REQ_LOCAL = 0;
  localparam int REQ_EAST  = 1;
  localparam int REQ_WEST  = 2;
  localparam int REQ_SOUTH = 3;
endpackage

// File: rtl/port_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder, first valid request at or after ptr wins
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    any = |req;
    // scan farthest-first so the nearest valid requester from ptr overwrites last
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/port_rr_arbiter.sv
// port_rr_arbiter: round-robin share of one output port into a registered valid/ready stage
// PORT_RR_ARBITER_DY_DECR_EN: decrement (saturating) the dy field of each packet on load
module port_rr_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW = PKT_W,
  localparam int SW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*PW-1:0] req_packet,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  output logic [PW-1:0]         out_packet,
  input  logic                  out_ready,
  output logic [SW-1:0]         out_src
);
  logic [SW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [SW-1:0]      idx;
  logic               any;
  logic               can_load;
  logic               load;
  logic [PW-1:0]      pkt_sel;
  logic [PW-1:0]      pkt_in;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(idx),
    .any(any)
  );

  assign can_load  = !out_valid | out_ready;
  assign load      = any & can_load;
  assign req_ready = rst ? '0 : grant & {NUM_REQ{can_load}};
  assign pkt_sel   = req_packet[idx*PW +: PW];

`ifdef PORT_RR_ARBITER_DY_DECR_EN
  logic [DY_HI-DY_LO:0] dy;
  assign dy     = pkt_sel[DY_HI:DY_LO];
  assign pkt_in = {pkt_sel[DX_HI:DX_LO], dy == '0 ? dy : dy - 1'b1, pkt_sel[PL_HI:PL_LO]};
`else
  assign pkt_in = pkt_sel;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
      out_src    <= '0;
      rr_ptr     <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_packet <= pkt_in;
      out_src    <= idx;
      rr_ptr     <= idx == SW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
endmodule

// File: tb/tb_port_rr_arbiter.sv
// tb_port_rr_arbiter: directed checks of reset, round robin, backpressure, drain and dy handling
module tb_port_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_packet = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [15:0] out_packet;
  logic        out_ready = 1'b1;
  logic [1:0]  out_src;
  int n_assert = 0;
  int n_fail = 0;

  port_rr_arbiter dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_packet(req_packet),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_packet(out_packet),
    .out_ready(out_ready),
    .out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dyd(input logic [15:0] p);
`ifdef PORT_RR_ARBITER_DY_DECR_EN
    return {p[15:12], p[11:8] == 4'h0 ? 4'h0 : p[11:8] - 4'h1, p[7:0]};
`else
    return p;
`endif
  endfunction

  initial begin
    // reset asserted mid-cycle with requests pending
    #2 rst = 1'b1;
    req_valid = 4'hf;
    #1;
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_packet", out_packet, 16'h0000);
    chk("rst_src", out_src, 2'd0);
    tick;
    chk("rst_hold_valid", out_valid, 1'b0);
    rst = 1'b0;
    req_valid = 4'h0;
    #1 chk("idle_ready", req_ready, 4'h0);
    // single requester (west)
    req_valid = 4'b0100;
    req_packet[32 +: 16] = 16'h0235;
    #1 chk("single_ready", req_ready, 4'b0100);
    tick;
    chk("single_valid", out_valid, 1'b1);
    chk("single_packet", out_packet, dyd(16'h0235));
    chk("single_src", out_src, 2'd2);
    req_valid = 4'h0;
    tick;
    chk("single_drain", out_valid, 1'b0);
    // pointer back to 0 via async reset pulse between edges
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) req_packet[i*16 +: 16] = 16'h00a0 + 16'(i);
    req_valid = 4'hf;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("rr_ready%0d", i), req_ready, 4'b0001 << (i % 4));
      tick;
      chk($sformatf("rr_src%0d", i), out_src, i % 4);
      chk($sformatf("rr_packet%0d", i), out_packet, 16'h00a0 + (i % 4));
      chk($sformatf("rr_valid%0d", i), out_valid, 1'b1);
    end
    // backpressure: pointer is now 2; load 1200 from west then stall
    req_valid = 4'b0100;
    req_packet[32 +: 16] = 16'h1200;
    #1 chk("bp_load_ready", req_ready, 4'b0100);
    tick;
    out_ready = 1'b0;
    req_valid = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp_ready%0d", i), req_ready, 4'h0);
      tick;
      chk($sformatf("bp_packet%0d", i), out_packet, dyd(16'h1200));
      chk($sformatf("bp_valid%0d", i), out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", req_ready, 4'b1000);
    tick;
    chk("bp_swap_valid", out_valid, 1'b1);
    chk("bp_swap_src", out_src, 2'd3);
    chk("bp_swap_packet", out_packet, 16'h00a3);
    // drain to empty; pointer stays at 0
    req_valid = 4'h0;
    tick;
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_packet", out_packet, 16'h00a3);
    chk("drain_src", out_src, 2'd3);
    req_valid = 4'b1010;
    #1 chk("drain_ptr_ready", req_ready, 4'b0010);
    tick;
    chk("drain_next_src", out_src, 2'd1);
    #1 chk("next_ready", req_ready, 4'b1000);
    tick;
    chk("wrap_src", out_src, 2'd3);
    #1 chk("wrap_ready", req_ready, 4'b0010);
    tick;
    // dy saturation and single decrement
    req_valid = 4'b0001;
    req_packet[0 +: 16] = 16'h3000;
    #1 chk("sat_ready", req_ready, 4'b0001);
    tick;
    chk("sat_packet", out_packet, 16'h3000);
    req_packet[0 +: 16] = 16'h3155;
    tick;
    chk("dy1_packet", out_packet, dyd(16'h3155));
    chk("dy1_src", out_src, 2'd0);
    // reset while full drops the packet immediately
    req_valid = 4'hf;
    #2 rst = 1'b1;
    #1;
    chk("rstfull_valid", out_valid, 1'b0);
    chk("rstfull_packet", out_packet, 16'h0000);
    chk("rstfull_src", out_src, 2'd0);
    chk("rstfull_ready", req_ready, 4'h0);
    rst = 1'b0;
    #1 chk("post_rst_ready", req_ready, 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
